// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, register map and FSM states for the FIR controller
package fir_pkg;

  localparam int TAP_NUM = 11;

  localparam int ADDR_AP_CTRL  = 'h00;
  localparam int ADDR_LEN      = 'h10;
  localparam int ADDR_TAP_BASE = 'h20;
  localparam int ADDR_TAP_LAST = 'h48;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_axil_slave.sv
// rtl/fir_axil_slave.sv - AXI-Lite handshakes reduced to single-cycle wr_en/rd_en strobes
module fir_axil_slave #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          awvalid_i,
  output logic          awready_o,
  input  logic [AW-1:0] awaddr_i,
  input  logic          wvalid_i,
  output logic          wready_o,
  input  logic [DW-1:0] wdata_i,
  input  logic          arvalid_i,
  output logic          arready_o,
  input  logic [AW-1:0] araddr_i,
  output logic          rvalid_o,
  input  logic          rready_i,
  output logic [DW-1:0] rdata_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_data_i
);

  logic          wr_ack_q, wr_ack_d;
  logic          ar_ack_q, ar_ack_d;
  logic          rvalid_q, rvalid_d;
  logic          rfirst_q, rfirst_d;
  logic [DW-1:0] rhold_q, rhold_d;
  logic          wr_pend;

  // A write about to be acknowledged blocks read acceptance, so writes win ties.
  always_comb begin
    wr_pend  = awvalid_i && wvalid_i && !wr_ack_q;
    wr_ack_d = wr_pend;
    ar_ack_d = arvalid_i && !ar_ack_q && !rvalid_q && !wr_pend;
    rvalid_d = ar_ack_q || (rvalid_q && !rready_i);
    rfirst_d = ar_ack_q;
    rhold_d  = rfirst_q ? rd_data_i : rhold_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ack_q <= 1'b0;
      ar_ack_q <= 1'b0;
      rvalid_q <= 1'b0;
      rfirst_q <= 1'b0;
      rhold_q  <= '0;
    end else begin
      wr_ack_q <= wr_ack_d;
      ar_ack_q <= ar_ack_d;
      rvalid_q <= rvalid_d;
      rfirst_q <= rfirst_d;
      rhold_q  <= rhold_d;
    end
  end

  // First rvalid cycle passes the live BRAM output; later cycles replay the held copy.
  assign rdata_o   = rfirst_q ? rd_data_i : rhold_q;
  assign awready_o = wr_ack_q;
  assign wready_o  = wr_ack_q;
  assign arready_o = ar_ack_q;
  assign rvalid_o  = rvalid_q;
  assign wr_en_o   = wr_ack_q;
  assign wr_addr_o = awaddr_i;
  assign wr_data_o = wdata_i;
  assign rd_en_o   = ar_ack_q;
  assign rd_addr_o = araddr_i;

endmodule

// File: rtl/fir_ctrl.sv
// rtl/fir_ctrl.sv - FIR register block, clear/run sequencer and tap/data BRAM arbitration
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = TAP_NUM
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic                   eng_tap_EN,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  input  logic [3:0]             eng_data_WE,
  input  logic                   eng_data_EN,
  input  logic [pDATA_WIDTH-1:0] eng_data_Di,
  input  logic [pADDR_WIDTH-1:0] eng_data_A,
  output logic                   eng_start,
  input  logic                   eng_done,
  output logic [31:0]            data_length
);

  localparam int CW = $clog2(Tape_Num);
  localparam logic [pADDR_WIDTH-1:0] A_CTRL     = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_LEN      = pADDR_WIDTH'(ADDR_LEN);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_BASE = pADDR_WIDTH'(ADDR_TAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_LAST = pADDR_WIDTH'(ADDR_TAP_LAST);

  logic                   wr_en, rd_en;
  logic [pADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [pDATA_WIDTH-1:0] wr_data, rd_data;

  fir_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ap_start_q, ap_start_d;
  logic                   ap_done_q, ap_done_d;
  logic                   eng_start_q, eng_start_d;
  logic [31:0]            len_q, len_d;
  logic                   rd_tap_q, rd_tap_d;
  logic                   rd_clr_q, rd_clr_d;
  logic [pDATA_WIDTH-1:0] rd_val_q, rd_val_d;

  logic                   ap_idle;
  logic [pDATA_WIDTH-1:0] ap_ctrl;
  logic                   wr_tap_hit, rd_tap_hit, start_req, done_rd_beat;

  fir_axil_slave #(.AW(pADDR_WIDTH), .DW(pDATA_WIDTH)) u_axil (
    .clk_i     (axis_clk),
    .rst_i     (axis_rst),
    .awvalid_i (awvalid),
    .awready_o (awready),
    .awaddr_i  (awaddr),
    .wvalid_i  (wvalid),
    .wready_o  (wready),
    .wdata_i   (wdata),
    .arvalid_i (arvalid),
    .arready_o (arready),
    .araddr_i  (araddr),
    .rvalid_o  (rvalid),
    .rready_i  (rready),
    .rdata_o   (rdata),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .rd_en_o   (rd_en),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data)
  );

  assign wr_tap_hit   = (wr_addr >= A_TAP_BASE) && (wr_addr <= A_TAP_LAST);
  assign rd_tap_hit   = (rd_addr >= A_TAP_BASE) && (rd_addr <= A_TAP_LAST);
  assign start_req    = wr_en && (wr_addr == A_CTRL) && wr_data[AP_START_BIT] &&
                        ((state_q == IDLE) || (state_q == DONE));
  assign done_rd_beat = rvalid && rready && rd_clr_q;
  assign rd_data      = rd_tap_q ? tap_Do : rd_val_q;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_req) state_d = CLEAR;
      CLEAR:   if (cnt_q == CW'(Tape_Num - 1)) state_d = RUN;
      RUN:     if (eng_done) state_d = DONE;
      DONE: begin
        if (start_req)         state_d = CLEAR;
        else if (done_rd_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ap_idle = (state_q == IDLE) || (state_q == DONE);
    ap_ctrl = '0;
    ap_ctrl[AP_START_BIT] = ap_start_q;
    ap_ctrl[AP_DONE_BIT]  = ap_done_q;
    ap_ctrl[AP_IDLE_BIT]  = ap_idle;

    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (state_q == RUN) begin
      tap_EN = eng_tap_EN;
      tap_A  = eng_tap_A;
    end else if (wr_en && wr_tap_hit) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = wr_addr - A_TAP_BASE;
      tap_Di = wr_data;
    end else if (rd_en && rd_tap_hit) begin
      tap_EN = 1'b1;
      tap_A  = rd_addr - A_TAP_BASE;
    end

    data_EN = 1'b0;
    data_WE = 4'h0;
    data_A  = '0;
    data_Di = '0;
    if (state_q == CLEAR) begin
      data_EN = 1'b1;
      data_WE = 4'hF;
      data_A  = pADDR_WIDTH'({cnt_q, 2'b00});
    end else if (state_q == RUN) begin
      data_EN = eng_data_EN;
      data_WE = eng_data_WE;
      data_A  = eng_data_A;
      data_Di = eng_data_Di;
    end
  end

  always_comb begin
    cnt_d       = (state_q == CLEAR) ? cnt_q + CW'(1) : '0;
    eng_start_d = (state_q == CLEAR) && (state_d == RUN);
    ap_start_d  = ap_start_q;
    if (start_req)              ap_start_d = 1'b1;
    else if (state_d == RUN)    ap_start_d = 1'b0;
    ap_done_d = ap_done_q;
    if ((state_q == RUN) && eng_done)             ap_done_d = 1'b1;
    else if ((state_q == DONE) && (state_d != DONE)) ap_done_d = 1'b0;
    len_d = len_q;
    if (wr_en && (wr_addr == A_LEN) && (state_q != RUN)) len_d = 32'(wr_data);

    // Non-BRAM read values are frozen at acceptance; tap reads use tap_Do next cycle.
    rd_tap_d = rd_tap_q;
    rd_clr_d = rd_clr_q;
    rd_val_d = rd_val_q;
    if (rd_en) begin
      rd_tap_d = rd_tap_hit && (state_q != RUN);
      rd_clr_d = (rd_addr == A_CTRL) && (state_q == DONE);
      rd_val_d = '0;
      if (rd_addr == A_CTRL)                     rd_val_d = ap_ctrl;
      else if (rd_addr == A_LEN)                 rd_val_d = pDATA_WIDTH'(len_q);
      else if (rd_tap_hit && (state_q == RUN))   rd_val_d = '1;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      cnt_q       <= '0;
      ap_start_q  <= 1'b0;
      ap_done_q   <= 1'b0;
      eng_start_q <= 1'b0;
      len_q       <= '0;
      rd_tap_q    <= 1'b0;
      rd_clr_q    <= 1'b0;
      rd_val_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ap_start_q  <= ap_start_d;
      ap_done_q   <= ap_done_d;
      eng_start_q <= eng_start_d;
      len_q       <= len_d;
      rd_tap_q    <= rd_tap_d;
      rd_clr_q    <= rd_clr_d;
      rd_val_q    <= rd_val_d;
    end
  end

  assign eng_start   = eng_start_q;
  assign data_length = len_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// tb/tb_fir_ctrl.sv - directed self-checking bench for fir_ctrl
module tb_fir_ctrl;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b1;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic        awready, wready, arready, rvalid;
  logic [31:0] rdata;
  logic [3:0]  tap_WE, data_WE;
  logic        tap_EN, data_EN;
  logic [31:0] tap_Di, data_Di;
  logic [11:0] tap_A, data_A;
  logic [31:0] tap_Do = '0;
  logic        eng_tap_EN = 1'b0, eng_data_EN = 1'b0, eng_done = 1'b0;
  logic [11:0] eng_tap_A = '0, eng_data_A = '0;
  logic [3:0]  eng_data_WE = '0;
  logic [31:0] eng_data_Di = '0;
  logic        eng_start;
  logic [31:0] data_length;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int start_n = 0;
  int start_cyc = 0;
  int clr_a[$];
  int clr_d[$];
  int clr_c[$];

  logic [31:0] tap_mem [16];
  int signed taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  always #5 axis_clk = ~axis_clk;

  fir_ctrl dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A),
    .eng_tap_EN(eng_tap_EN), .eng_tap_A(eng_tap_A),
    .eng_data_WE(eng_data_WE), .eng_data_EN(eng_data_EN),
    .eng_data_Di(eng_data_Di), .eng_data_A(eng_data_A),
    .eng_start(eng_start), .eng_done(eng_done), .data_length(data_length)
  );

  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) tap_mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= tap_mem[tap_A[5:2]];
    end
  end

  always @(negedge axis_clk) begin
    cyc = cyc + 1;
    if (data_EN && data_WE == 4'hF) begin
      clr_a.push_back(int'(data_A));
      clr_d.push_back(int'(data_Di));
      clr_c.push_back(cyc);
    end
    if (eng_start) begin
      start_n = start_n + 1;
      start_cyc = cyc;
    end
  end

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    bit got = 0;
    @(negedge axis_clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge axis_clk);
      if (awready && wready) got = 1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL write_handshake addr=%h: awready/wready=0 after 20 cycles, required 1", a);
    end
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d);
    bit got_ar = 0;
    bit got_r = 0;
    d = 32'hDEAD_BEEF;
    @(negedge axis_clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20 && !got_ar; i++) begin
      @(negedge axis_clk);
      if (arready) got_ar = 1;
    end
    arvalid = 1'b0;
    for (int i = 0; i < 20 && got_ar && !got_r; i++) begin
      if (i > 0 || !rvalid) @(negedge axis_clk);
      if (rvalid) begin got_r = 1; d = rdata; end
    end
    n_cmp++;
    if (!got_r) begin
      n_bad++;
      $display("FAIL read_handshake addr=%h: arready=%0b rvalid=0, required rvalid=1", a, got_ar);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(negedge axis_clk);
    n_cmp++;
    if ({awready, wready, arready, rvalid, eng_start, tap_EN, data_EN, tap_WE, data_WE} !== 15'h0) begin
      n_bad++;
      $display("FAIL reset_ctrl_outs: got %b, required 0", {awready, wready, arready, rvalid, eng_start, tap_EN, data_EN, tap_WE, data_WE});
    end
    n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
    n_cmp++;
    if (data_length !== 32'h0) begin n_bad++; $display("FAIL reset_len: got %h, required 0", data_length); end
    axis_rst = 1'b0;
    do_read(12'h000, r);
    n_cmp++;
    if (r !== 32'h4) begin n_bad++; $display("FAIL reset_ap_ctrl: got %h, required 4", r); end
  endtask

  task automatic test_program();
    logic [31:0] r;
    do_write(12'h010, 32'd600);
    for (int k = 0; k < 11; k++) do_write(12'h020 + 12'(4 * k), 32'(taps[k]));
    for (int k = 0; k < 11; k++) begin
      do_read(12'h020 + 12'(4 * k), r);
      n_cmp++;
      if (r !== 32'(taps[k])) begin n_bad++; $display("FAIL tap_readback[%0d]: got %h, required %h", k, r, 32'(taps[k])); end
    end
    do_read(12'h010, r);
    n_cmp++;
    if (r !== 32'd600) begin n_bad++; $display("FAIL len_readback: got %0d, required 600", r); end
    n_cmp++;
    if (data_length !== 32'd600) begin n_bad++; $display("FAIL len_port: got %0d, required 600", data_length); end
    do_read(12'h000, r);
    n_cmp++;
    if (r !== 32'h4) begin n_bad++; $display("FAIL prog_ap_ctrl: got %h, required 4", r); end
    do_read(12'h080, r);
    n_cmp++;
    if (r !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h, required 0", r); end
  endtask

  task automatic test_start();
    int base = clr_a.size();
    int sbase = start_n;
    int n;
    logic [31:0] r;
    do_write(12'h000, 32'h1);
    repeat (16) @(negedge axis_clk);
    n = clr_a.size() - base;
    n_cmp++;
    if (n != 11) begin n_bad++; $display("FAIL clear_count: got %0d, required 11", n); end
    for (int k = 0; k < 11 && k < n; k++) begin
      n_cmp++;
      if (clr_a[base + k] != 4 * k || clr_d[base + k] != 0 || clr_c[base + k] != clr_c[base] + k) begin
        n_bad++;
        $display("FAIL clear_word[%0d]: got A=%0d D=%0d dcyc=%0d, required A=%0d D=0 dcyc=%0d",
                 k, clr_a[base + k], clr_d[base + k], clr_c[base + k] - clr_c[base], 4 * k, k);
      end
    end
    n_cmp++;
    if (start_n - sbase != 1) begin n_bad++; $display("FAIL eng_start_count: got %0d, required 1", start_n - sbase); end
    if (n > 0) begin
      n_cmp++;
      if (start_cyc != clr_c[base + n - 1] + 1) begin
        n_bad++;
        $display("FAIL eng_start_timing: got cycle %0d, required %0d", start_cyc, clr_c[base + n - 1] + 1);
      end
    end
    do_read(12'h000, r);
    n_cmp++;
    if (r !== 32'h0) begin n_bad++; $display("FAIL run_ap_ctrl: got %h, required 0", r); end
    @(negedge axis_clk);
    eng_tap_EN = 1'b1; eng_tap_A = 12'h008;
    eng_data_EN = 1'b1; eng_data_WE = 4'hF; eng_data_A = 12'h014; eng_data_Di = 32'h1234;
    #1;
    n_cmp++;
    if ({tap_EN, tap_WE, tap_A, data_EN, data_WE, data_A, data_Di} !== {1'b1, 4'h0, 12'h008, 1'b1, 4'hF, 12'h014, 32'h1234}) begin
      n_bad++;
      $display("FAIL run_mux: got tapEN=%b tapA=%h dataEN=%b dataA=%h dataDi=%h, required 1 008 1 014 00001234",
               tap_EN, tap_A, data_EN, data_A, data_Di);
    end
    #1;
    eng_tap_EN = 1'b0; eng_tap_A = '0;
    eng_data_EN = 1'b0; eng_data_WE = '0; eng_data_A = '0; eng_data_Di = '0;
  endtask

  task automatic test_run_lockout();
    logic [31:0] r;
    do_write(12'h024, 32'd99);
    do_read(12'h024, r);
    n_cmp++;
    if (r !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL run_tap_read: got %h, required ffffffff", r); end
    do_read(12'h010, r);
    n_cmp++;
    if (r !== 32'd600) begin n_bad++; $display("FAIL run_len_read: got %0d, required 600", r); end
    do_write(12'h010, 32'd5);
    n_cmp++;
    if (data_length !== 32'd600) begin n_bad++; $display("FAIL run_len_write: got %0d, required 600", data_length); end
    do_write(12'h000, 32'h1);
    do_read(12'h000, r);
    n_cmp++;
    if (r !== 32'h0) begin n_bad++; $display("FAIL run_start_write: got %h, required 0", r); end
  endtask

  task automatic test_complete();
    logic [31:0] r;
    @(negedge axis_clk); eng_done = 1'b1;
    @(negedge axis_clk); eng_done = 1'b0;
    do_read(12'h000, r);
    n_cmp++;
    if (r !== 32'h6) begin n_bad++; $display("FAIL done_ap_ctrl: got %h, required 6", r); end
    do_read(12'h000, r);
    n_cmp++;
    if (r !== 32'h4) begin n_bad++; $display("FAIL done_cleared: got %h, required 4", r); end
    do_read(12'h024, r);
    n_cmp++;
    if (r !== 32'hFFFF_FFF6) begin n_bad++; $display("FAIL tap1_kept: got %h, required fffffff6", r); end
    @(negedge axis_clk); eng_done = 1'b1;
    @(negedge axis_clk); eng_done = 1'b0;
    do_read(12'h000, r);
    n_cmp++;
    if (r !== 32'h4) begin n_bad++; $display("FAIL idle_done_ignored: got %h, required 4", r); end
  endtask

  task automatic test_back_to_back();
    bit got = 0;
    int hits = 0;
    bit prev = 0;
    bit adj = 0;
    @(negedge axis_clk);
    araddr = 12'h028; arvalid = 1'b1; rready = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge axis_clk);
      if (rvalid) got = 1;
      if (arready) arvalid = 1'b0;
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL hold_rvalid: rvalid=0 after 20 cycles, required 1"); end
    araddr = 12'h02C; arvalid = 1'b1;
    do_write(12'h020, 32'h0);
    rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge axis_clk);
      n_cmp++;
      if ({rvalid, arready, rdata} !== {1'b1, 1'b0, 32'hFFFF_FFF7}) begin
        n_bad++;
        $display("FAIL hold_stable[%0d]: got rvalid=%b arready=%b rdata=%h, required 1 0 fffffff7", i, rvalid, arready, rdata);
      end
    end
    rready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge axis_clk);
      if (arready) arvalid = 1'b0;
      if (rvalid && !arvalid) begin
        got = 1;
        n_cmp++;
        if (rdata !== 32'd23) begin n_bad++; $display("FAIL queued_read: got %h, required 00000017", rdata); end
      end
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL queued_read_timeout: rvalid=0, required 1"); end
    arvalid = 1'b0;
    @(negedge axis_clk);
    awaddr = 12'h010; wdata = 32'd600; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge axis_clk);
      if (awready) hits++;
      if (awready && prev) adj = 1;
      prev = awready;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n_cmp++;
    if (hits != 3 || adj) begin n_bad++; $display("FAIL write_rate: got %0d acks adjacent=%0b, required 3 acks adjacent=0", hits, adj); end
  endtask

  task automatic test_concurrent();
    int aw_i = -1;
    int ar_i = -1;
    int rv_i = -1;
    logic [31:0] r = '0;
    @(negedge axis_clk);
    awaddr = 12'h010; wdata = 32'd777; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h010; arvalid = 1'b1; rready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge axis_clk);
      if (awready && aw_i < 0) begin aw_i = i; awvalid = 1'b0; wvalid = 1'b0; end
      if (arready && ar_i < 0) begin ar_i = i; arvalid = 1'b0; end
      if (rvalid && rv_i < 0) begin rv_i = i; r = rdata; end
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n_cmp++;
    if (aw_i != 1 || ar_i != 2) begin n_bad++; $display("FAIL concurrent_order: got aw@%0d ar@%0d, required aw@1 ar@2", aw_i, ar_i); end
    n_cmp++;
    if (rv_i != 3) begin n_bad++; $display("FAIL concurrent_rvalid: got cycle %0d, required 3", rv_i); end
    n_cmp++;
    if (r !== 32'd777) begin n_bad++; $display("FAIL concurrent_data: got %0d, required 777", r); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r;
    do_write(12'h000, 32'h1);
    repeat (14) @(negedge axis_clk);
    araddr = 12'h000; arvalid = 1'b1;
    eng_tap_EN = 1'b1; eng_data_EN = 1'b1; eng_data_WE = 4'hF;
    axis_rst = 1'b1;
    @(negedge axis_clk);
    n_cmp++;
    if ({eng_start, tap_EN, data_EN, tap_WE, data_WE, arready, rvalid} !== 13'h0) begin
      n_bad++;
      $display("FAIL midrun_outs: got %b, required 0", {eng_start, tap_EN, data_EN, tap_WE, data_WE, arready, rvalid});
    end
    n_cmp++;
    if (data_length !== 32'h0) begin n_bad++; $display("FAIL midrun_len: got %0d, required 0", data_length); end
    arvalid = 1'b0;
    eng_tap_EN = 1'b0; eng_data_EN = 1'b0; eng_data_WE = '0;
    @(negedge axis_clk);
    axis_rst = 1'b0;
    do_read(12'h000, r);
    n_cmp++;
    if (r !== 32'h4) begin n_bad++; $display("FAIL midrun_ap_ctrl: got %h, required 4", r); end
    do_read(12'h010, r);
    n_cmp++;
    if (r !== 32'h0) begin n_bad++; $display("FAIL midrun_len_read: got %h, required 0", r); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tap_mem[i] = '0;
    test_reset();
    test_program();
    test_start();
    test_run_lockout();
    test_complete();
    test_back_to_back();
    test_concurrent();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
